// File: rtl/gf180mcu_osu_sc_gp12t3v3__tiebank_pkg.sv
// Shared definitions for the sequenced tie bank: state encoding and parameter defaults.
package gf180mcu_osu_sc_gp12t3v3__tiebank_pkg;

    // FSM state encoding (kept as plain constants for legacy netlist compatibility)
    localparam logic [1:0] HOLD  = 2'b00;
    localparam logic [1:0] COUNT = 2'b01;
    localparam logic [1:0] TIE   = 2'b10;

    // Default configuration
    localparam int unsigned DEF_WIDTH    = 8;
    localparam logic [7:0]  DEF_SAFE_VAL = 8'h00;
    localparam logic [7:0]  DEF_TIE_VAL  = 8'hFF;
    localparam int unsigned DEF_DELAY    = 4;
    localparam int unsigned DEF_CW       = 8;

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__tiebank_cnt.sv
// Settle-delay counter: synchronous clear, count enable, saturates at DELAY-1.
// done is high whenever the count sits at its terminal value.
module gf180mcu_osu_sc_gp12t3v3__tiebank_cnt #(
    parameter int unsigned CW    = 8,
    parameter int unsigned DELAY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [CW-1:0] LAST = (DELAY == 0) ? '0 : CW'(DELAY - 1);

    logic [CW-1:0] cnt;

    assign done = (cnt == LAST);

    // Count up while enabled, hold at LAST, clear whenever the FSM leaves COUNT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !done) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__tiebank_seq.sv
// Reset-sequenced tie bank. Y holds SAFE_VAL until EN has been held long enough,
// then drives the loadable pattern register. Optional sticky lock: TIEBANK_LOCK_EN.
module gf180mcu_osu_sc_gp12t3v3__tiebank_seq
    import gf180mcu_osu_sc_gp12t3v3__tiebank_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SAFE_VAL = WIDTH'(DEF_SAFE_VAL),
    parameter logic [WIDTH-1:0] TIE_VAL  = WIDTH'(DEF_TIE_VAL),
    parameter int unsigned      DELAY    = DEF_DELAY,
    parameter int unsigned      CW       = DEF_CW
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             EN,
    input  logic             LD,
`ifdef TIEBANK_LOCK_EN
    input  logic             LOCK,
`endif
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] Y,
    output logic             RDY
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] pat;
    logic             locked;
    logic             stay;
    logic             ld_ok;
    logic             cnt_done;

    assign stay  = EN || locked;
    assign ld_ok = LD && !locked;

    gf180mcu_osu_sc_gp12t3v3__tiebank_cnt #(
        .CW    (CW),
        .DELAY (DELAY)
    ) u_cnt (
        .clk  (CLK),
        .rst  (R),
        .clr  (state != COUNT),
        .en   (EN),
        .done (cnt_done)
    );

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            HOLD: begin
                if (EN) state_nxt = (DELAY == 0) ? TIE : COUNT;
            end
            COUNT: begin
                if (!EN)          state_nxt = HOLD;
                else if (cnt_done) state_nxt = TIE;
            end
            TIE: begin
                if (!stay) state_nxt = HOLD;
            end
            default: state_nxt = HOLD;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge R) begin
        if (R) state <= HOLD;
        else   state <= state_nxt;
    end

    // Pattern register: LD always lands here unless the bank is locked
    always_ff @(posedge CLK or posedge R) begin
        if (R)          pat <= TIE_VAL;
        else if (ld_ok) pat <= DIN;
    end

    // Output register. Y lags entry into TIE by one edge, but drops on the same
    // edge that leaves TIE; a coincident load is forwarded straight to Y.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            Y   <= SAFE_VAL;
            RDY <= 1'b0;
        end else if ((state == TIE) && stay) begin
            Y   <= ld_ok ? DIN : pat;
            RDY <= 1'b1;
        end else begin
            Y   <= SAFE_VAL;
            RDY <= 1'b0;
        end
    end

`ifdef TIEBANK_LOCK_EN
    // Sticky lock, armed only while the bank is (and stays) in TIE; cleared by R only
    always_ff @(posedge CLK or posedge R) begin
        if (R)                                  locked <= 1'b0;
        else if (LOCK && (state == TIE) && stay) locked <= 1'b1;
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__tiebank_seq.sv
// Bench for the sequenced tie bank: one DELAY=4 and one DELAY=0 instance share stimulus.
// Reference model: Y shows the pattern once EN has been sampled high on DELAY+2
// consecutive edges since the last low sample or reset.
module tb_gf180mcu_osu_sc_gp12t3v3__tiebank_seq;

    logic       CLK = 1'b0;
    logic       R, EN, LD, LOCK;
    logic [7:0] DIN;
    logic [7:0] y4, y0;
    logic       rdy4, rdy0;

    int checks = 0;
    int errors = 0;

    int         run [2];
    logic [7:0] pat [2];
    bit         lk  [2];
    int         dly [2] = '{4, 0};

    always #5 CLK = ~CLK;

    gf180mcu_osu_sc_gp12t3v3__tiebank_seq #(
        .WIDTH(8), .SAFE_VAL(8'h00), .TIE_VAL(8'hFF), .DELAY(4), .CW(8)
    ) dut4 (
        .CLK(CLK), .R(R), .EN(EN), .LD(LD),
`ifdef TIEBANK_LOCK_EN
        .LOCK(LOCK),
`endif
        .DIN(DIN), .Y(y4), .RDY(rdy4)
    );

    gf180mcu_osu_sc_gp12t3v3__tiebank_seq #(
        .WIDTH(8), .SAFE_VAL(8'h00), .TIE_VAL(8'hFF), .DELAY(0), .CW(8)
    ) dut0 (
        .CLK(CLK), .R(R), .EN(EN), .LD(LD),
`ifdef TIEBANK_LOCK_EN
        .LOCK(LOCK),
`endif
        .DIN(DIN), .Y(y0), .RDY(rdy0)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            run[i] = 0;
            pat[i] = 8'hFF;
            lk[i]  = 1'b0;
        end
    endtask

    // {y4, rdy4, y0, rdy0} as the model predicts it
    function automatic logic [17:0] expv();
        logic [8:0] e [2];
        for (int i = 0; i < 2; i++) begin
            if (run[i] >= dly[i] + 2) e[i] = {pat[i], 1'b1};
            else                      e[i] = {8'h00, 1'b0};
        end
        return {e[0], e[1]};
    endfunction

    // Advance one clock edge and apply the model, then settle 1 time unit
    task automatic tick();
        @(posedge CLK);
        if (R) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit nl;
                nl = lk[i];
`ifdef TIEBANK_LOCK_EN
                if (LOCK && run[i] >= dly[i] + 1 && (EN || lk[i])) nl = 1'b1;
`endif
                if (LD && !lk[i]) pat[i] = DIN;
                if (EN || lk[i]) run[i] = (run[i] < 1000) ? run[i] + 1 : run[i];
                else             run[i] = 0;
                lk[i] = nl;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse placed mid-cycle
    task automatic pulse_reset(input string name);
        #2;
        R = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({y4, rdy4, y0, rdy0} !== expv()) begin
            errors++;
            $display("FAIL %s_async got %h exp %h", name, {y4, rdy4, y0, rdy0}, expv());
        end
        #1;
        R = 1'b0;
    endtask

    task automatic test_reset();
        R = 1'b1; EN = 1'b1; LD = 1'b1; LOCK = 1'b0; DIN = 8'($urandom);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({y4, rdy4, y0, rdy0} !== 18'h0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got %h exp %h", c, {y4, rdy4, y0, rdy0}, 18'h0);
            end
        end
        R = 1'b0; LD = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            checks++;
            if ({y4, rdy4, y0, rdy0} !== expv()) begin
                errors++;
                $display("FAIL reset_release cyc%0d got %h exp %h", c, {y4, rdy4, y0, rdy0}, expv());
            end
            if (c == 5) begin
                checks++;
                if ({y4, rdy4} !== {8'h00, 1'b0}) begin
                    errors++;
                    $display("FAIL release_early got %h exp 000", {y4, rdy4});
                end
            end
            if (c == 6) begin
                checks++;
                if ({y4, rdy4} !== {8'hFF, 1'b1}) begin
                    errors++;
                    $display("FAIL release_latency got %h exp 1ff", {y4, rdy4});
                end
            end
        end
    endtask

    task automatic test_abort();
        pulse_reset("abort");
        for (int c = 0; c < 11; c++) begin
            EN = (c == 2) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if ({y4, rdy4, y0, rdy0} !== expv()) begin
                errors++;
                $display("FAIL abort cyc%0d got %h exp %h", c, {y4, rdy4, y0, rdy0}, expv());
            end
            if (c == 7) begin
                checks++;
                if (y4 !== 8'h00) begin
                    errors++;
                    $display("FAIL abort_restart got %h exp 00", y4);
                end
            end
        end
    endtask

    task automatic test_load_tie();
        EN = 1'b1; LD = 1'b1; DIN = 8'hA5;
        tick();
        LD = 1'b0;
        checks++;
        if ({y4, rdy4, y0, rdy0} !== expv() || y4 !== 8'hA5) begin
            errors++;
            $display("FAIL load_tie got %h exp %h", {y4, rdy4, y0, rdy0}, expv());
        end
        for (int c = 0; c < 8; c++) begin
            EN = (c == 0) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if ({y4, rdy4, y0, rdy0} !== expv()) begin
                errors++;
                $display("FAIL load_retain cyc%0d got %h exp %h", c, {y4, rdy4, y0, rdy0}, expv());
            end
        end
        checks++;
        if ({y4, rdy4} !== {8'hA5, 1'b1}) begin
            errors++;
            $display("FAIL pat_retained got %h exp 14b", {y4, rdy4});
        end
    endtask

    task automatic test_delay0();
        pulse_reset("delay0");
        EN = 1'b1;
        tick();
        LD = 1'b1; DIN = 8'h3C;
        tick();
        LD = 1'b0;
        checks++;
        if ({y4, rdy4, y0, rdy0} !== expv() || {y0, rdy0} !== {8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL delay0_load got %h exp %h", {y4, rdy4, y0, rdy0}, expv());
        end
    endtask

    task automatic test_async_reset();
        pulse_reset("pre");
        EN = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        pulse_reset("in_count");
        for (int c = 0; c < 7; c++) tick();
        LD = 1'b1; DIN = 8'h5A;
        tick();
        LD = 1'b0;
        pulse_reset("in_tie");
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if ({y4, rdy4, y0, rdy0} !== expv()) begin
                errors++;
                $display("FAIL after_reset cyc%0d got %h exp %h", c, {y4, rdy4, y0, rdy0}, expv());
            end
        end
        checks++;
        if (y4 !== 8'hFF) begin
            errors++;
            $display("FAIL pat_reset got %h exp ff", y4);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            R    = ($urandom_range(0, 59) == 0);
            EN   = ($urandom_range(0, 9) != 0);
            LD   = ($urandom_range(0, 4) == 0);
            DIN  = 8'($urandom);
`ifdef TIEBANK_LOCK_EN
            LOCK = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) R = 1'b1;
`endif
            tick();
            checks++;
            if ({y4, rdy4, y0, rdy0} !== expv()) begin
                errors++;
                $display("FAIL random cyc%0d got %h exp %h", c, {y4, rdy4, y0, rdy0}, expv());
            end
        end
        R = 1'b0; LD = 1'b0; LOCK = 1'b0;
    endtask

`ifdef TIEBANK_LOCK_EN
    task automatic test_lock();
        pulse_reset("lock_pre");
        EN = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        LOCK = 1'b1;
        tick();
        LOCK = 1'b0; LD = 1'b1; DIN = 8'h11; EN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({y4, rdy4, y0, rdy0} !== expv() || {y4, rdy4} !== {8'hFF, 1'b1}) begin
                errors++;
                $display("FAIL lock_hold cyc%0d got %h exp %h", c, {y4, rdy4, y0, rdy0}, expv());
            end
        end
        LD = 1'b0;
        pulse_reset("lock_clear");
        tick();
        checks++;
        if ({y4, rdy4, y0, rdy0} !== 18'h0) begin
            errors++;
            $display("FAIL lock_cleared got %h exp %h", {y4, rdy4, y0, rdy0}, 18'h0);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_abort();
        test_load_tie();
        test_delay0();
        test_async_reset();
`ifdef TIEBANK_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
